fb_scanout: RTL

Frame-buffer scanout engine: the read side of the 320x240, 8-bit-per-pixel frame buffer that the rasterizer writes. It generates 640x480@60 VGA timing, reads each frame-buffer pixel with 2x horizontal and vertical replication, expands RGB332 to RGB444, and drives sync and data-enable. It also exposes a front-buffer select, latched only at frame boundaries, and a vblank/frame_done handshake, so the renderer can swap double buffers without tearing.

---
 rtl/fb_scanout.sv | 111 +++++++++++
 1 files changed

// File: rtl/fb_scanout.sv
// Frame-buffer scanout: 640x480@60 VGA timing over a 320x240 RGB332 buffer with
// 2x replication, RGB444 expansion and a frame-boundary front-buffer select.
module fb_scanout (
  input  logic        clk,
  input  logic        rst,
  input  logic        front_buf,
  output logic        fb_en,
  output logic [17:0] fb_addr,
  input  logic [7:0]  fb_dout,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic        vblank,
  output logic        frame_done
);
  localparam logic [9:0]  H_LAST   = 10'd799;
  localparam logic [9:0]  H_ACT    = 10'd640;
  localparam logic [9:0]  HS_BEG   = 10'd656;
  localparam logic [9:0]  HS_END   = 10'd751;
  localparam logic [9:0]  V_LAST   = 10'd524;
  localparam logic [9:0]  V_ACT    = 10'd480;
  localparam logic [9:0]  VS_BEG   = 10'd490;
  localparam logic [9:0]  VS_END   = 10'd491;
  localparam logic [16:0] ROW_STEP = 17'd320;

  logic [9:0]  hc_r, vc_r, hc_nxt_s, vc_nxt_s;
  logic [16:0] row_base_r;
  logic        buf_q_r;
  logic        active_s, hs_s, vs_s, line_end_s, frame_end_s;
  logic [1:0]  de_d_r, hs_d_r, vs_d_r;

  // RGB332 -> RGB444 by replicating the top bits into the new LSBs
  function automatic logic [11:0] expand332(input logic [7:0] d);
    expand332 = {d[7:5], d[7], d[4:2], d[4], d[1:0], d[1:0]};
  endfunction

  // Timing decode and next-counter values
  always_comb begin
    line_end_s  = (hc_r == H_LAST);
    frame_end_s = line_end_s && (vc_r == V_LAST);
    active_s    = (hc_r < H_ACT) && (vc_r < V_ACT);
    hs_s        = ~((hc_r >= HS_BEG) && (hc_r <= HS_END));
    vs_s        = ~((vc_r >= VS_BEG) && (vc_r <= VS_END));
    hc_nxt_s    = line_end_s ? 10'd0 : hc_r + 10'd1;
    if (!line_end_s) begin
      vc_nxt_s = vc_r;
    end else if (vc_r == V_LAST) begin
      vc_nxt_s = 10'd0;
    end else begin
      vc_nxt_s = vc_r + 10'd1;
    end
  end

  // Counters, row base, buffer latch; handshake flags track the new counter value
  always_ff @(posedge clk) begin
    if (rst) begin
      hc_r       <= 10'd0;
      vc_r       <= 10'd0;
      row_base_r <= 17'd0;
      buf_q_r    <= 1'b0;
      vblank     <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      hc_r       <= hc_nxt_s;
      vc_r       <= vc_nxt_s;
      vblank     <= (vc_nxt_s >= V_ACT);
      frame_done <= (hc_nxt_s == 10'd0) && (vc_nxt_s == V_ACT);
      if (frame_end_s) begin
        row_base_r <= 17'd0;
        buf_q_r    <= front_buf;
      end else if (line_end_s && (vc_r < V_ACT) && vc_r[0]) begin
        row_base_r <= row_base_r + ROW_STEP;
      end
    end
  end

  // Read request stage and the sync/enable delay line up to the BRAM output
  always_ff @(posedge clk) begin
    if (rst) begin
      fb_en   <= 1'b0;
      fb_addr <= 18'd0;
      de_d_r  <= 2'b00;
      hs_d_r  <= 2'b11;
      vs_d_r  <= 2'b11;
    end else begin
      fb_en   <= active_s;
      fb_addr <= active_s ? {buf_q_r, row_base_r + {8'd0, hc_r[9:1]}} : 18'd0;
      de_d_r  <= {de_d_r[0], active_s};
      hs_d_r  <= {hs_d_r[0], hs_s};
      vs_d_r  <= {vs_d_r[0], vs_s};
    end
  end

  // Output registers; color is blanked whenever the delayed enable is low
  always_ff @(posedge clk) begin
    if (rst) begin
      de                    <= 1'b0;
      hsync                 <= 1'b1;
      vsync                 <= 1'b1;
      {vga_r, vga_g, vga_b} <= 12'd0;
    end else begin
      de                    <= de_d_r[1];
      hsync                 <= hs_d_r[1];
      vsync                 <= vs_d_r[1];
      {vga_r, vga_g, vga_b} <= de_d_r[1] ? expand332(fb_dout) : 12'd0;
    end
  end
endmodule
